// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bus: PC/instruction/hazard inputs from the pipeline and the
// IF/ID register contents plus fetch status driven back by the stage.
interface if_id_fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic [63:0]      PC_Current;
    logic [31:0]      Instruction;
    logic             Stall;
    logic             Branch_Taken;
    logic [63:0]      Branch_Target;
    logic [63:0]      PC_Next;
    logic [63:0]      IF_ID_PC;
    logic [31:0]      IF_ID_Instruction;
    logic             IF_ID_Valid;
    logic [1:0]       Fetch_State;
    logic [CNT_W-1:0] Fetch_Count;
    logic             Fetch_Error;

    modport master (
        output PC_Current, Instruction, Stall, Branch_Taken, Branch_Target,
        input  PC_Next, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
               Fetch_State, Fetch_Count, Fetch_Error
    );

    modport slave (
        input  PC_Current, Instruction, Stall, Branch_Taken, Branch_Target,
        output PC_Next, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
               Fetch_State, Fetch_Count, Fetch_Error
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage: next-PC selection and the IF/ID pipeline register,
// with stall hold, branch flush, saturating fetch counter and misalignment flag.
module if_id_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    if_id_fetch_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    logic [63:0]      w_pc_next;
    logic [63:0]      r_if_id_pc;
    logic [31:0]      r_if_id_instr;
    logic             r_if_id_valid;
    fetch_state_e     r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_error;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_pc_next = bus.PC_Current + 64'd4;
        if (bus.Branch_Taken) begin
            w_pc_next = {bus.Branch_Target[63:2], 2'b00};
        end else if (bus.Stall) begin
            w_pc_next = bus.PC_Current;
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id_pc    <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_state       <= ST_RUN;
            r_count       <= '0;
            r_error       <= 1'b0;
        end else if (bus.Branch_Taken) begin
            r_if_id_pc    <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_state       <= ST_FLUSH;
            if (bus.Branch_Target[1:0] != 2'b00) begin
                r_error <= 1'b1;
            end
        end else if (bus.Stall) begin
            r_state <= ST_STALL;
        end else begin
            r_if_id_pc    <= bus.PC_Current;
            r_if_id_instr <= bus.Instruction;
            r_if_id_valid <= 1'b1;
            r_state       <= ST_RUN;
            // Counter saturates rather than wrapping.
            if (r_count != '1) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.PC_Next           = w_pc_next;
    assign bus.IF_ID_PC          = r_if_id_pc;
    assign bus.IF_ID_Instruction = r_if_id_instr;
    assign bus.IF_ID_Valid       = r_if_id_valid;
    assign bus.Fetch_State       = r_state;
    assign bus.Fetch_Count       = r_count;
    assign bus.Fetch_Error       = r_error;
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed vector table, hand-written
// corner sequences, and randomized traffic against an abstract behavioural model.
module tb_if_id_fetch_stage;
    logic clk = 1'b0;
    logic reset;
    logic reset4;

    always #5 clk = ~clk;

    if_id_fetch_stage_if #(.CNT_W(32)) bus ();
    if_id_fetch_stage_if #(.CNT_W(4))  bus4 ();

    if_id_fetch_stage #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    if_id_fetch_stage #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .bus   (bus4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the IF/ID contents and status.
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    int          m_state;
    longint      m_count;
    logic        m_err;
    localparam longint CNT_MAX = 64'd4294967295;

    typedef struct {
        logic        rst;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] e_pc_next;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [1:0]  e_state;
        logic [31:0] e_count;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [63:0] pc, input logic [31:0] ins,
                         input logic s, input logic b, input logic [63:0] t);
        reset             = r;
        bus.PC_Current    = pc;
        bus.Instruction   = ins;
        bus.Stall         = s;
        bus.Branch_Taken  = b;
        bus.Branch_Target = t;
    endtask

    function automatic logic [63:0] model_pc_next();
        if (bus.Branch_Taken) return bus.Branch_Target - (bus.Branch_Target % 64'd4);
        if (bus.Stall) return bus.PC_Current;
        return bus.PC_Current + 64'd4;
    endfunction

    // Advance one clock and apply the fetch rules to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pc = 64'h0; m_instr = 32'h13; m_valid = 1'b0;
            m_state = 0; m_count = 0; m_err = 1'b0;
        end else if (bus.Branch_Taken) begin
            m_pc = 64'h0; m_instr = 32'h13; m_valid = 1'b0; m_state = 2;
            if (bus.Branch_Target % 64'd4 != 0) m_err = 1'b1;
        end else if (bus.Stall) begin
            m_state = 1;
        end else begin
            m_pc = bus.PC_Current; m_instr = bus.Instruction; m_valid = 1'b1;
            m_state = 0;
            if (m_count < CNT_MAX) m_count++;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    bus.IF_ID_PC, m_pc);
        check({tag, ".instr"}, 64'(bus.IF_ID_Instruction), 64'(m_instr));
        check({tag, ".valid"}, 64'(bus.IF_ID_Valid), 64'(m_valid));
        check({tag, ".state"}, 64'(bus.Fetch_State), 64'(m_state));
        check({tag, ".count"}, 64'(bus.Fetch_Count), 64'(m_count));
        check({tag, ".err"},   64'(bus.Fetch_Error), 64'(m_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rpc;
        reset4 = 1'b1;
        bus4.PC_Current = '0; bus4.Instruction = '0; bus4.Stall = 1'b0;
        bus4.Branch_Taken = 1'b0; bus4.Branch_Target = '0;

        //          rst pc        instr         st br tgt     pc_next   if_pc     if_instr      v  state cnt err
        vecs[0] = '{1, 64'h0,  32'h1111_1111, 0, 0, 64'h0,  64'h4,  64'h0,  32'h0000_0013, 0, 0, 0, 0};
        vecs[1] = '{0, 64'h0,  32'hAAAA_0001, 0, 0, 64'h0,  64'h4,  64'h0,  32'hAAAA_0001, 1, 0, 1, 0};
        vecs[2] = '{0, 64'h4,  32'hBBBB_0002, 0, 0, 64'h0,  64'h8,  64'h4,  32'hBBBB_0002, 1, 0, 2, 0};
        vecs[3] = '{0, 64'h8,  32'hCCCC_0003, 1, 0, 64'h0,  64'h8,  64'h4,  32'hBBBB_0002, 1, 1, 2, 0};
        vecs[4] = '{0, 64'h8,  32'hCCCC_0003, 1, 0, 64'h0,  64'h8,  64'h4,  32'hBBBB_0002, 1, 1, 2, 0};
        vecs[5] = '{0, 64'h8,  32'hCCCC_0003, 0, 0, 64'h0,  64'hC,  64'h8,  32'hCCCC_0003, 1, 0, 3, 0};
        vecs[6] = '{0, 64'hC,  32'hDDDD_0004, 1, 1, 64'h40, 64'h40, 64'h0,  32'h0000_0013, 0, 2, 3, 0};
        vecs[7] = '{0, 64'h40, 32'hEEEE_0005, 0, 0, 64'h0,  64'h44, 64'h40, 32'hEEEE_0005, 1, 0, 4, 0};
        vecs[8] = '{0, 64'h44, 32'hFFFF_0006, 0, 1, 64'h46, 64'h44, 64'h0,  32'h0000_0013, 0, 2, 4, 1};
        vecs[9] = '{0, 64'h44, 32'hFFFF_0006, 1, 0, 64'h0,  64'h44, 64'h0,  32'h0000_0013, 0, 1, 4, 1};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].pc, vecs[i].instr, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            #1;
            check($sformatf("vec%0d.pc_next", i), bus.PC_Next, vecs[i].e_pc_next);
            tick();
            check($sformatf("vec%0d.if_pc", i), bus.IF_ID_PC, vecs[i].e_pc);
            check($sformatf("vec%0d.if_instr", i), 64'(bus.IF_ID_Instruction), 64'(vecs[i].e_instr));
            check($sformatf("vec%0d.valid", i), 64'(bus.IF_ID_Valid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d.state", i), 64'(bus.Fetch_State), 64'(vecs[i].e_state));
            check($sformatf("vec%0d.count", i), 64'(bus.Fetch_Count), 64'(vecs[i].e_count));
            check($sformatf("vec%0d.err", i), 64'(bus.Fetch_Error), 64'(vecs[i].e_err));
        end

        // Sticky error persists across ten more cycles of normal fetch.
        for (int i = 0; i < 10; i++) begin
            drive(0, 64'h100 + 64'(i * 4), $urandom, 0, 0, 64'h0);
            tick();
            check("err_sticky", 64'(bus.Fetch_Error), 64'h1);
        end

        // PC wrap at the top of the address space.
        drive(0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_5678, 0, 0, 64'h0);
        #1;
        check("pc_wrap", bus.PC_Next, 64'h0);
        tick();
        check_model("wrap");

        // Reset mid-stall with five loads counted; also PC_Next keeps its rule during reset.
        drive(1, 64'h0, 32'h0, 0, 0, 64'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 64'(i * 4), 32'h0A00_0000 + 32'(i), 0, 0, 64'h0);
            tick();
        end
        check("pre_reset_count", 64'(bus.Fetch_Count), 64'd5);
        drive(0, 64'h14, 32'h0B00_0000, 1, 0, 64'h0);
        tick();
        drive(1, 64'h14, 32'h0B00_0000, 1, 1, 64'h83);
        #1;
        check("pc_next_in_reset", bus.PC_Next, 64'h80);
        tick();
        check("rst.pc", bus.IF_ID_PC, 64'h0);
        check("rst.instr", 64'(bus.IF_ID_Instruction), 64'h13);
        check("rst.valid", 64'(bus.IF_ID_Valid), 64'h0);
        check("rst.state", 64'(bus.Fetch_State), 64'h0);
        check("rst.count", 64'(bus.Fetch_Count), 64'h0);
        check("rst.err", 64'(bus.Fetch_Error), 64'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rpc = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                              : {$urandom, $urandom} & ~64'h3;
            drive($urandom_range(0, 29) == 0, rpc, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                  {$urandom, $urandom});
            #1;
            check("rand.pc_next", bus.PC_Next, model_pc_next());
            tick();
            check_model("rand");
        end

        // Saturation of a 4-bit counter after 20 loads.
        @(posedge clk);
        #1;
        reset4 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            bus4.PC_Current  = 64'(i * 4);
            bus4.Instruction = 32'(i);
            @(posedge clk);
            #1;
            check("sat.count", 64'(bus4.Fetch_Count), 64'((i > 15) ? 15 : i));
        end
        check("sat.final", 64'(bus4.Fetch_Count), 64'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/if_id_fetch_stage.md
IF_ID_FETCH_STAGE -- requirements
Module: if_id_fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0, the IF/ID PC value held while in reset or flushed.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000013, the bubble encoding (addi x0,x0,0).
REQ-003 SHALL provide parameter CNT_W, default 32, the width of Fetch_Count.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 PC_Current  input  64  current PC from the program counter register.
REQ-007 Instruction  input  32  instruction memory word at PC_Current.
REQ-008 Stall  input  1  load-use hazard; hold PC and IF/ID.
REQ-009 Branch_Taken  input  1  branch/jump resolved taken; redirect and flush.
REQ-010 Branch_Target  input  64  redirect address.
REQ-011 PC_Next  output  64  next PC, driven to the program counter PC_In.
REQ-012 IF_ID_PC  output  64  registered PC of the instruction in ID.
REQ-013 IF_ID_Instruction  output  32  registered instruction in ID.
REQ-014 IF_ID_Valid  output  1  1 = IF_ID_Instruction is a real fetched instruction.
REQ-015 Fetch_State  output  2  registered state: 0 RUN, 1 STALL, 2 FLUSH.
REQ-016 Fetch_Count  output  CNT_W  number of valid instructions loaded into IF/ID.
REQ-017 Fetch_Error  output  1  sticky misaligned-redirect flag.

Function
REQ-018 PC_Next SHALL be combinational: Branch_Taken -> {Branch_Target[63:2],2'b00}; else Stall -> PC_Current; else PC_Current + 4, modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-019 Branch_Taken SHALL take priority over Stall in every rule.
REQ-020 PC_Next SHALL follow the REQ-018 rule during reset; the program counter applies its own reset.
REQ-021 On a posedge with Branch_Taken=1 (flush), IF/ID SHALL load IF_ID_PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_Valid=0.
REQ-022 On a posedge with Stall=1 and Branch_Taken=0, IF_ID_PC, IF_ID_Instruction and IF_ID_Valid SHALL hold.
REQ-023 Otherwise IF/ID SHALL load PC_Current, Instruction and Valid=1 (latency: one cycle from fetch to ID).
REQ-024 Fetch_State SHALL be the next state registered each posedge: Branch_Taken -> FLUSH; else Stall -> STALL; else RUN. FLUSH therefore lasts exactly one cycle unless a further branch arrives.
REQ-025 Fetch_Count SHALL increment by 1 on each posedge that executes REQ-023 and saturate at all-ones (no wrap).
REQ-026 Fetch_Error SHALL be set on any posedge with Branch_Taken=1 and Branch_Target[1:0]!=0, and SHALL remain set until reset.
REQ-027 A continuously asserted Stall SHALL hold IF/ID and PC indefinitely, with Fetch_Count unchanged.

Reset
REQ-028 While reset=1 at a posedge: IF_ID_PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_Valid=0, Fetch_State=RUN, Fetch_Count=0, Fetch_Error=0; reset SHALL override Stall and Branch_Taken.
REQ-029 Reset asserted mid-stall or mid-flush SHALL take effect at the next posedge with no residual state.
REQ-030 The first posedge after reset deassertion SHALL load the PC_Current/Instruction pair present (normally PC 0).

Verification
REQ-031 Sequential fetch: reset, then PC_Current=0,4,8 with Instruction=A,B,C -> PC_Next=4,8,12; IF_ID shows (0,A),(4,B),(8,C) one cycle later, Valid=1, Fetch_Count=3.
REQ-032 Stall: at PC_Current=8 assert Stall for 2 cycles -> PC_Next=8; IF_ID holds (4,B); Fetch_State=STALL; Fetch_Count unchanged; resumes with (8,C).
REQ-033 Branch over stall: Stall=1, Branch_Taken=1, Branch_Target=0x40 -> PC_Next=0x40; next cycle IF_ID=(0,0x00000013), Valid=0, Fetch_State=FLUSH.
REQ-034 Misaligned target: Branch_Target=0x46 -> PC_Next=0x44, Fetch_Error=1 and still 1 after 10 further cycles; cleared only by reset.
REQ-035 Wrap/saturation: PC_Current=64'hFFFF_FFFF_FFFF_FFFC -> PC_Next=0; with CNT_W=4, 20 loads -> Fetch_Count=4'hF.
REQ-036 Reset mid-operation: reset during Stall=1 with Fetch_Count=5 -> next posedge all outputs at REQ-028 values.
